ysyx_22041412_div: RTL and testbench

- Iterative RV64M divide/remainder unit; the multi-cycle counterpart to the single-cycle ALU in the EXU.
- Executes DIV/DIVU/REM/REMU and the W forms DIVW/DIVUW/REMW/REMUW.
- Accepts operands through a valid/ready handshake, runs a radix-2 restoring loop, and returns the 64-bit writeback value through a valid/ready handshake.
- The EXU stalls on `in_ready`/`out_valid`.

---
 rtl/ysyx_22041412_div_pkg.sv | 31 +++
 rtl/ysyx_22041412_div.sv | 275 +++++++++++++++++++++++++++
 tb/tb_ysyx_22041412_div.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22041412_div_pkg.sv
// Shared constants for the iterative RV64M divide/remainder unit:
// datapath sizing, FSM state encodings, func3 codes and latencies.
package ysyx_22041412_div_pkg;

  // Datapath width and iteration counter width (holds 0..XLEN)
  localparam int DIV_XLEN  = 64;
  localparam int DIV_CNT_W = 7;

  // FSM state encodings (2-bit, legacy-compatible constants)
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // func3 codes of the M-extension divide group
  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  // Bit positions inside func3 that steer the unit
  localparam int F3_UNSIGNED_BIT = 0;
  localparam int F3_REM_BIT      = 1;
  localparam int F3_GROUP_BIT    = 2;

  // Accept-edge to out_valid latency, in cycles
  localparam int LAT_DWORD   = 66;
  localparam int LAT_WORD    = 34;
  localparam int LAT_SPECIAL = 1;

endpackage

// File: rtl/ysyx_22041412_div.sv
// Iterative RV64M divider: DIV/DIVU/REM/REMU and their W forms.
// Radix-2 restoring loop on magnitudes, one sign/width fixup cycle,
// valid/ready handshakes on both sides. Divide-by-zero and signed
// overflow are resolved at accept and skip the loop entirely.
module ysyx_22041412_div
  import ysyx_22041412_div_pkg::*;
#(
  parameter int XLEN  = DIV_XLEN,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] scr1,
  input  logic [XLEN-1:0] scr2,
  input  logic [2:0]      func3,
  input  logic            word,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int HALF = XLEN / 2;
  // Most-negative value of the active width, as seen after extension
  localparam logic [XLEN-1:0] MIN_D = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MIN_W = {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}};

  // Control state
  logic [1:0]      r_state;
  logic            r_in_ready;
  logic            r_out_valid;
  logic [XLEN-1:0] r_result;
  logic [CNT_W-1:0] r_cnt;

  // Operation context latched at accept
  logic            r_word;
  logic            r_want_rem;
  logic            r_neg_q;
  logic            r_neg_r;

  // Loop datapath: partial remainder, quotient/dividend shifter, |divisor|
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_dvs;

  // Decode wires
  logic            w_accept;
  logic            w_signed;
  logic            w_want_rem;
  logic [XLEN-1:0] w_a_ext;
  logic [XLEN-1:0] w_b_ext;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic            w_div_zero;
  logic            w_ovf;
  logic            w_special;
  logic [XLEN-1:0] w_spec_raw;
  logic [XLEN-1:0] w_spec_res;

  // Loop step wires
  logic [XLEN:0]   w_shift;
  logic            w_ge;
  logic [XLEN-1:0] w_diff;
  logic [XLEN-1:0] w_rem_nxt;
  logic [XLEN-1:0] w_quo_nxt;
  logic            w_calc_last;

  // Fixup wires
  logic [XLEN-1:0] w_q_fix;
  logic [XLEN-1:0] w_r_fix;
  logic [XLEN-1:0] w_sel;
  logic [XLEN-1:0] w_fix_res;

  logic [1:0]      w_state_nxt;

  assign w_accept = (r_state == S_IDLE) & in_valid & ~flush;

  // Decode func3/word, extend operands, take magnitudes, detect special cases
  always_comb begin
    w_signed   = 1'b1;
    w_want_rem = 1'b0;
    w_a_ext    = scr1;
    w_b_ext    = scr2;
    // func3[2]=0 is outside the divide group; it is executed as plain DIV
    if (func3[F3_GROUP_BIT]) begin
      w_signed   = ~func3[F3_UNSIGNED_BIT];
      w_want_rem = func3[F3_REM_BIT];
    end else begin
      w_signed   = 1'b1;
      w_want_rem = 1'b0;
    end
    if (word) begin
      if (w_signed) begin
        w_a_ext = {{HALF{scr1[HALF-1]}}, scr1[HALF-1:0]};
        w_b_ext = {{HALF{scr2[HALF-1]}}, scr2[HALF-1:0]};
      end else begin
        w_a_ext = {{HALF{1'b0}}, scr1[HALF-1:0]};
        w_b_ext = {{HALF{1'b0}}, scr2[HALF-1:0]};
      end
    end else begin
      w_a_ext = scr1;
      w_b_ext = scr2;
    end
    w_a_neg = w_signed & w_a_ext[XLEN-1];
    w_b_neg = w_signed & w_b_ext[XLEN-1];
    // Negating the most-negative value returns the same bit pattern,
    // which is exactly the unsigned magnitude wanted
    if (w_a_neg) begin
      w_a_mag = ~w_a_ext + {{(XLEN-1){1'b0}}, 1'b1};
    end else begin
      w_a_mag = w_a_ext;
    end
    if (w_b_neg) begin
      w_b_mag = ~w_b_ext + {{(XLEN-1){1'b0}}, 1'b1};
    end else begin
      w_b_mag = w_b_ext;
    end
    w_div_zero = (w_b_ext == {XLEN{1'b0}});
    w_ovf      = w_signed & (w_b_ext == {XLEN{1'b1}}) &
                 (w_a_ext == (word ? MIN_W : MIN_D));
    w_special  = w_div_zero | w_ovf;
    if (w_div_zero) begin
      w_spec_raw = w_want_rem ? w_a_ext : {XLEN{1'b1}};
    end else begin
      w_spec_raw = w_want_rem ? {XLEN{1'b0}} : w_a_ext;
    end
    if (word) begin
      w_spec_res = {{HALF{w_spec_raw[HALF-1]}}, w_spec_raw[HALF-1:0]};
    end else begin
      w_spec_res = w_spec_raw;
    end
  end

  // One restoring step: shift {rem,quo} left, subtract |b| if it fits
  always_comb begin
    w_shift = {r_rem, r_quo[XLEN-1]};
    w_ge    = (w_shift >= {1'b0, r_dvs});
    // Only used when w_ge holds, so the difference fits in XLEN bits
    w_diff  = w_shift[XLEN-1:0] - r_dvs;
    if (w_ge) begin
      w_rem_nxt = w_diff;
    end else begin
      w_rem_nxt = w_shift[XLEN-1:0];
    end
    w_quo_nxt   = {r_quo[XLEN-2:0], w_ge};
    w_calc_last = (r_cnt == {{(CNT_W-1){1'b0}}, 1'b1});
  end

  // Sign fixup, quotient/remainder select and W-form sign extension
  always_comb begin
    if (r_neg_q) begin
      w_q_fix = ~r_quo + {{(XLEN-1){1'b0}}, 1'b1};
    end else begin
      w_q_fix = r_quo;
    end
    if (r_neg_r) begin
      w_r_fix = ~r_rem + {{(XLEN-1){1'b0}}, 1'b1};
    end else begin
      w_r_fix = r_rem;
    end
    w_sel = r_want_rem ? w_r_fix : w_q_fix;
    // Sign-extend bit 31 for every W form, DIVUW/REMUW included
    if (r_word) begin
      w_fix_res = {{HALF{w_sel[HALF-1]}}, w_sel[HALF-1:0]};
    end else begin
      w_fix_res = w_sel;
    end
  end

  // Next-state logic; flush overrides everything except reset
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            w_state_nxt = w_special ? S_DONE : S_CALC;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_CALC: begin
          if (w_calc_last) begin
            w_state_nxt = S_FIX;
          end else begin
            w_state_nxt = S_CALC;
          end
        end
        S_FIX: begin
          w_state_nxt = S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // State register with registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == S_IDLE);
      r_out_valid <= (w_state_nxt == S_DONE);
    end
  end

  // Operand latch, iteration datapath, counter and result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem      <= {XLEN{1'b0}};
      r_quo      <= {XLEN{1'b0}};
      r_dvs      <= {XLEN{1'b0}};
      r_cnt      <= {CNT_W{1'b0}};
      r_word     <= 1'b0;
      r_want_rem <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_result   <= {XLEN{1'b0}};
    end else if (flush) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (w_accept) begin
      r_rem      <= {XLEN{1'b0}};
      r_dvs      <= w_b_mag;
      r_word     <= word;
      r_want_rem <= w_want_rem;
      r_neg_q    <= w_signed & (w_a_neg ^ w_b_neg);
      r_neg_r    <= w_signed & w_a_neg;
      // Word dividends are left-aligned so 32 steps consume all their bits
      if (word) begin
        r_quo <= {w_a_mag[HALF-1:0], {HALF{1'b0}}};
        r_cnt <= CNT_W'(HALF);
      end else begin
        r_quo <= w_a_mag;
        r_cnt <= CNT_W'(XLEN);
      end
      if (w_special) begin
        r_result <= w_spec_res;
        r_cnt    <= {CNT_W{1'b0}};
      end else begin
        r_result <= r_result;
      end
    end else if (r_state == S_CALC) begin
      r_rem <= w_rem_nxt;
      r_quo <= w_quo_nxt;
      r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (r_state == S_FIX) begin
      r_result <= w_fix_res;
    end else begin
      r_result <= r_result;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;

endmodule

// File: tb/tb_ysyx_22041412_div.sv
// Scoreboard bench for ysyx_22041412_div: the driver pushes the expected
// result and latency at each accept; an independent monitor pops and
// compares whenever the unit presents out_valid.
module tb_ysyx_22041412_div;
  import ysyx_22041412_div_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] scr1;
  logic [63:0] scr2;
  logic [2:0]  func3;
  logic        word;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;

  typedef struct {
    string       name;
    logic [63:0] exp;
    int          lat;
    time         t_acc;
    int          hold;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  bit   seen_unexp = 1'b0;

  ysyx_22041412_div dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .scr1      (scr1),
    .scr2      (scr2),
    .func3     (func3),
    .word      (word),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%h, want 0x%h", nm, got, want);
    end
  endtask

  task automatic timeout(input string nm);
    n_vec++;
    n_bad++;
    $display("FAIL %s: timed out waiting on the unit", nm);
  endtask

  // Wait (at negedges) until the unit can accept; bounded
  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Issue one operation; optionally record its expectation on the scoreboard
  task automatic issue(input string nm, input logic [2:0] f3, input logic w,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] want, input int lat, input int hold,
                       input bit track);
    bit   ok;
    exp_t e;
    wait_ready(ok);
    if (!ok) begin
      timeout({nm, "_accept"});
    end else begin
      func3    = f3;
      word     = w;
      scr1     = a;
      scr2     = b;
      in_valid = 1'b1;
      @(posedge clk);
      if (track) begin
        e.name  = nm;
        e.exp   = want;
        e.lat   = lat;
        e.t_acc = $time;
        e.hold  = hold;
        sb.push_back(e);
      end
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic drain(input string nm);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (sb.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) timeout(nm);
  endtask

  // Monitor: compares result and latency, optionally stalls out_ready,
  // then confirms the handshake returns the unit to IDLE
  initial begin : monitor
    int          phase;
    int          hold_left;
    logic [63:0] held;
    exp_t        e;
    phase     = 0;
    hold_left = 0;
    held      = 64'd0;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        phase     = 0;
        out_ready = 1'b0;
      end else if (phase == 2) begin
        chk({e.name, "_post_ov"}, {63'd0, out_valid}, 64'd0);
        chk({e.name, "_post_ir"}, {63'd0, in_ready}, 64'd1);
        out_ready = 1'b0;
        void'(sb.pop_front());
        phase = 0;
      end else if (phase == 1) begin
        chk({e.name, "_stall_ov"}, {63'd0, out_valid}, 64'd1);
        chk({e.name, "_stable"}, result, held);
        hold_left--;
        if (hold_left == 0) begin
          out_ready = 1'b1;
          phase     = 2;
        end
      end else if (out_valid) begin
        if (sb.size() == 0) begin
          seen_unexp = 1'b1;
        end else begin
          e = sb[0];
          chk({e.name, "_lat"}, 64'(($time + 5 - e.t_acc) / 10), 64'(e.lat));
          chk(e.name, result, e.exp);
          held = result;
          if (e.hold > 0) begin
            hold_left = e.hold;
            phase     = 1;
          end else begin
            out_ready = 1'b1;
            phase     = 2;
          end
        end
      end
    end
  end

  // Stimulus
  initial begin : driver
    rst_n    = 1'b0;
    in_valid = 1'b0;
    flush    = 1'b0;
    func3    = 3'b000;
    word     = 1'b0;
    scr1     = 64'd0;
    scr2     = 64'd0;

    #12;
    chk("rst_ov", {63'd0, out_valid}, 64'd0);
    chk("rst_res", result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ir", {63'd0, in_ready}, 64'd1);

    // 64-bit signed/unsigned divide and remainder
    issue("div_m7_2",  F3_DIV,  1'b0, -64'd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, LAT_DWORD, 0, 1'b1);
    issue("rem_m7_2",  F3_REM,  1'b0, -64'd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, LAT_DWORD, 0, 1'b1);
    issue("divu_max",  F3_DIVU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'h0FFF_FFFF_FFFF_FFFF, LAT_DWORD, 0, 1'b1);
    issue("remu_max",  F3_REMU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'hF, LAT_DWORD, 0, 1'b1);
    // Divide by zero
    issue("div_z",     F3_DIV,  1'b0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, LAT_SPECIAL, 0, 1'b1);
    issue("rem_z",     F3_REM,  1'b0, 64'h1234, 64'd0, 64'h1234, LAT_SPECIAL, 0, 1'b1);
    issue("divuw_z",   F3_DIVU, 1'b1, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, LAT_SPECIAL, 0, 1'b1);
    // Signed overflow
    issue("div_ovf",   F3_DIV,  1'b0, 64'h8000_0000_0000_0000, -64'd1, 64'h8000_0000_0000_0000, LAT_SPECIAL, 0, 1'b1);
    issue("rem_ovf",   F3_REM,  1'b0, 64'h8000_0000_0000_0000, -64'd1, 64'd0, LAT_SPECIAL, 0, 1'b1);
    issue("divw_ovf",  F3_DIV,  1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, LAT_SPECIAL, 0, 1'b1);
    // W forms
    issue("divuw_hi",  F3_DIVU, 1'b1, 64'hAAAA_AAAA_8000_0000, 64'd2, 64'h4000_0000, LAT_WORD, 0, 1'b1);
    issue("remw_m9_4", F3_REM,  1'b1, -64'd9, 64'd4, 64'hFFFF_FFFF_FFFF_FFFF, LAT_WORD, 0, 1'b1);
    issue("divuw_sx",  F3_DIVU, 1'b1, 64'hFFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, LAT_WORD, 0, 1'b1);
    issue("remuw_hi",  F3_REMU, 1'b1, 64'h1_0000_0007, 64'd5, 64'd2, LAT_WORD, 0, 1'b1);
    issue("divw_m7_2", F3_DIV,  1'b1, -64'd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, LAT_WORD, 0, 1'b1);
    // Result held stable while out_ready stays low
    issue("divu_hold", F3_DIVU, 1'b0, 64'd100, 64'd7, 64'd14, LAT_DWORD, 5, 1'b1);
    drain("drain_main");

    // Flush during CALC: the op must vanish
    issue("flush_op",  F3_DIVU, 1'b0, 64'd1000, 64'd3, 64'd0, 0, 0, 1'b0);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_ir", {63'd0, in_ready}, 64'd1);
    chk("flush_ov", {63'd0, out_valid}, 64'd0);

    // in_valid together with flush in IDLE is not accepted
    @(negedge clk);
    func3    = F3_DIVU;
    word     = 1'b0;
    scr1     = 64'd1000;
    scr2     = 64'd3;
    in_valid = 1'b1;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    @(negedge clk);
    chk("flush_idle_ir", {63'd0, in_ready}, 64'd1);
    repeat (80) @(posedge clk);
    chk("flush_no_out", {63'd0, seen_unexp}, 64'd0);

    issue("divu_aft_fl", F3_DIVU, 1'b0, 64'd1000, 64'd3, 64'd333, LAT_DWORD, 0, 1'b1);
    issue("remu_aft_fl", F3_REMU, 1'b0, 64'd1000, 64'd3, 64'd1, LAT_DWORD, 0, 1'b1);
    drain("drain_flush");

    // Reset in the middle of CALC
    issue("rst_op", F3_DIV, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd3, 64'd0, 0, 0, 1'b0);
    repeat (20) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_ov", {63'd0, out_valid}, 64'd0);
    chk("midrst_res", result, 64'd0);
    chk("midrst_ir", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (80) @(posedge clk);
    chk("midrst_no_out", {63'd0, seen_unexp}, 64'd0);

    issue("div_aft_rst", F3_DIV, 1'b0, 64'd100, -64'd7, 64'hFFFF_FFFF_FFFF_FFF2, LAT_DWORD, 0, 1'b1);
    issue("rem_aft_rst", F3_REM, 1'b0, 64'd100, -64'd7, 64'd2, LAT_DWORD, 0, 1'b1);
    drain("drain_final");
    chk("no_unexpected_out", {63'd0, seen_unexp}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
